// File: rtl/sized_fifo_if.sv
// sized_fifo_if: producer/consumer bundle for sized_fifo.
// Parameters: width (data bits), depth (entries, sets COUNT width).
// Signals: D_IN/ENQ (enqueue side), D_OUT/DEQ (dequeue side),
//          FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY (status),
//          OVF/UDF (sticky error flags, constant 0 unless SIZED_FIFO_ERR_EN).
// Modports: master (user of the FIFO), slave (the FIFO itself).
interface sized_fifo_if #(
    parameter int width = 1,
    parameter int depth = 4
);
    localparam int cw = $clog2(depth + 1);
    logic [width-1:0] D_IN;
    logic             ENQ;
    logic             FULL_N;
    logic [width-1:0] D_OUT;
    logic             DEQ;
    logic             EMPTY_N;
    logic [cw-1:0]    COUNT;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    logic             OVF;
    logic             UDF;
    modport master (
        output D_IN, ENQ, DEQ,
        input  FULL_N, D_OUT, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, OVF, UDF
    );
    modport slave (
        input  D_IN, ENQ, DEQ,
        output FULL_N, D_OUT, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, OVF, UDF
    );
endinterface

// File: rtl/sized_fifo.sv
// sized_fifo: parametrised synchronous FIFO of any depth >= 2 with occupancy flags.
// Ports: CLK (clock), RST_N (async active-low reset), CLR (sync clear, retains storage),
//        q (sized_fifo_if.slave: D_IN/ENQ/FULL_N, D_OUT/DEQ/EMPTY_N, COUNT,
//        ALMOST_FULL, ALMOST_EMPTY, OVF, UDF).
// Optional feature: define SIZED_FIFO_ERR_EN to build sticky OVF/UDF capture;
// otherwise OVF/UDF are tied to 0.
module sized_fifo #(
    parameter int width    = 1,
    parameter int depth    = 4,
    parameter bit guarded  = 1'b1,
    parameter int af_level = depth - 1,
    parameter int ae_level = 1
) (
    input logic         CLK,
    input logic         RST_N,
    input logic         CLR,
    sized_fifo_if.slave q
);
    localparam int cw = $clog2(depth + 1);
    localparam int pw = $clog2(depth);
    logic [width-1:0] mem [depth];
    logic [pw-1:0]    rptr, wptr;
    logic [cw-1:0]    count;
    logic             full_n, empty_n, write_en, read_en;
    // Explicit wrap so non-power-of-two depths never rely on binary overflow.
    function automatic logic [pw-1:0] nxt(input logic [pw-1:0] p);
        return p == pw'(depth - 1) ? '0 : p + 1'b1;
    endfunction
    assign full_n   = count < cw'(depth);
    assign empty_n  = count != '0;
    // A guarded full FIFO accepts the write into the slot the same-cycle read frees.
    assign write_en = q.ENQ & (full_n | (guarded & q.DEQ));
    assign read_en  = q.DEQ & empty_n;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (CLR) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (write_en) begin
                mem[wptr] <= q.D_IN;
                wptr      <= nxt(wptr);
            end
            if (read_en) rptr <= nxt(rptr);
            count <= count + cw'(write_en) - cw'(read_en);
        end
    assign q.FULL_N       = full_n;
    assign q.EMPTY_N      = empty_n;
    assign q.COUNT        = count;
    assign q.D_OUT        = mem[rptr];
    assign q.ALMOST_FULL  = count >= cw'(af_level);
    assign q.ALMOST_EMPTY = count <= cw'(ae_level);
`ifdef SIZED_FIFO_ERR_EN
    logic ovf, udf;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (CLR) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf | (q.ENQ & ~write_en);
            udf <= udf | (q.DEQ & ~empty_n);
        end
    assign q.OVF = ovf;
    assign q.UDF = udf;
`else
    assign q.OVF = 1'b0;
    assign q.UDF = 1'b0;
`endif
endmodule

// File: tb/tb_sized_fifo.sv
// tb_sized_fifo: directed self-checking bench for sized_fifo (width 8, depth 5),
// one guarded and one unguarded instance driven with identical stimulus.
module tb_sized_fifo;
`ifdef SIZED_FIFO_ERR_EN
    localparam logic err_on = 1'b1;
`else
    localparam logic err_on = 1'b0;
`endif
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic CLR = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    sized_fifo_if #(.width(8), .depth(5)) i1 ();
    sized_fifo_if #(.width(8), .depth(5)) i0 ();
    sized_fifo #(.width(8), .depth(5), .guarded(1'b1), .af_level(4), .ae_level(1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .q(i1)
    );
    sized_fifo #(.width(8), .depth(5), .guarded(1'b0), .af_level(4), .ae_level(1)) u0 (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .q(i0)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic set(input logic enq, input logic deq, input logic [7:0] din);
        i1.ENQ = enq; i1.DEQ = deq; i1.D_IN = din;
        i0.ENQ = enq; i0.DEQ = deq; i0.D_IN = din;
    endtask
    task automatic step();
        @(posedge CLK);
        #1;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_full_n"}, i1.FULL_N, 1'b1);
        chk({tag, "_empty_n"}, i1.EMPTY_N, 1'b0);
        chk({tag, "_count"}, i1.COUNT, 0);
        chk({tag, "_dout"}, i1.D_OUT, 0);
        chk({tag, "_ae"}, i1.ALMOST_EMPTY, 1'b1);
        chk({tag, "_af"}, i1.ALMOST_FULL, 1'b0);
        chk({tag, "_ovf"}, i1.OVF, 1'b0);
        chk({tag, "_udf"}, i1.UDF, 1'b0);
        chk({tag, "_count0"}, i0.COUNT, 0);
    endtask
    initial begin
        set(1'b0, 1'b0, 8'h00);
        #12;
        chk_reset("rst");
        RST_N = 1'b1;
        // Fill with 0x11..0x55
        for (int i = 1; i <= 5; i++) begin
            set(1'b1, 1'b0, 8'(8'h11 * i));
            step();
            chk("fill_count", i1.COUNT, i);
            chk("fill_af", i1.ALMOST_FULL, i >= 4);
            chk("fill_full_n", i1.FULL_N, i < 5);
            chk("fill_dout", i1.D_OUT, 8'h11);
        end
        // Drain
        for (int k = 1; k <= 5; k++) begin
            set(1'b0, 1'b1, 8'h00);
            step();
            chk("drain_count", i1.COUNT, 5 - k);
            chk("drain_ae", i1.ALMOST_EMPTY, (5 - k) <= 1);
            chk("drain_empty_n", i1.EMPTY_N, k < 5);
            if (k < 5) chk("drain_dout", i1.D_OUT, 8'h11 * (k + 1));
        end
        // Wrap-around: 3 in, 3 out, then 7 simultaneous cycles
        for (int i = 1; i <= 3; i++) begin
            set(1'b1, 1'b0, 8'(i));
            step();
        end
        chk("wrap_count3", i1.COUNT, 3);
        for (int k = 1; k <= 3; k++) begin
            set(1'b0, 1'b1, 8'h00);
            step();
            if (k < 3) chk("wrap_dout_pre", i1.D_OUT, k + 1);
        end
        chk("wrap_empty", i1.EMPTY_N, 1'b0);
        for (int i = 0; i < 7; i++) begin
            set(1'b1, 1'b1, 8'(8'hA0 + i));
            step();
            chk("wrap_dout", i1.D_OUT, 8'hA0 + i);
            chk("wrap_count", i1.COUNT, 1);
        end
        chk("wrap_udf", i1.UDF, err_on);
        set(1'b0, 1'b1, 8'h00);
        step();
        chk("wrap_final_count", i1.COUNT, 0);
        // Full boundary: 0x31..0x35 then ENQ&DEQ with 0xEE
        for (int i = 1; i <= 5; i++) begin
            set(1'b1, 1'b0, 8'(8'h30 + i));
            step();
        end
        chk("full_count1", i1.COUNT, 5);
        chk("full_count0", i0.COUNT, 5);
        chk("full_full_n", i0.FULL_N, 1'b0);
        set(1'b1, 1'b1, 8'hEE);
        step();
        chk("g1_count", i1.COUNT, 5);
        chk("g1_dout", i1.D_OUT, 8'h32);
        chk("g1_ovf", i1.OVF, 1'b0);
        chk("g0_count", i0.COUNT, 4);
        chk("g0_dout", i0.D_OUT, 8'h32);
        chk("g0_ovf", i0.OVF, err_on);
        for (int k = 1; k <= 5; k++) begin
            set(1'b0, 1'b1, 8'h00);
            step();
            chk("g1_drain_count", i1.COUNT, 5 - k);
            if (k < 5) chk("g1_drain_dout", i1.D_OUT, k == 4 ? 8'hEE : 8'h32 + k);
            if (k < 4) chk("g0_drain_dout", i0.D_OUT, 8'h32 + k);
            if (k == 4) chk("g0_drain_empty", i0.COUNT, 0);
        end
        // Clear, then empty boundary
        set(1'b0, 1'b0, 8'h00);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_ovf0", i0.OVF, 1'b0);
        chk("clr_udf1", i1.UDF, 1'b0);
        chk("clr_count", i1.COUNT, 0);
        set(1'b0, 1'b1, 8'h00);
        step();
        chk("udf_count", i1.COUNT, 0);
        chk("udf_empty_n", i1.EMPTY_N, 1'b0);
        chk("udf_full_n", i1.FULL_N, 1'b1);
        chk("udf_flag", i1.UDF, err_on);
        set(1'b1, 1'b1, 8'h5A);
        step();
        chk("ed_count", i1.COUNT, 1);
        chk("ed_empty_n", i1.EMPTY_N, 1'b1);
        chk("ed_dout", i1.D_OUT, 8'h5A);
        // CLR with ENQ at COUNT=3
        set(1'b1, 1'b0, 8'h61);
        step();
        set(1'b1, 1'b0, 8'h62);
        step();
        chk("c3_count", i1.COUNT, 3);
        chk("c3_udf", i1.UDF, err_on);
        set(1'b1, 1'b0, 8'h77);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        chk("clr_enq_count", i1.COUNT, 0);
        chk("clr_enq_empty_n", i1.EMPTY_N, 1'b0);
        chk("clr_enq_ovf", i1.OVF, 1'b0);
        chk("clr_enq_udf", i1.UDF, 1'b0);
        // Refill to 4 from cleared pointers, then async reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            set(1'b1, 1'b0, 8'(8'h88 + i));
            step();
        end
        chk("pre_rst_count", i1.COUNT, 4);
        chk("pre_rst_af", i1.ALMOST_FULL, 1'b1);
        chk("pre_rst_dout", i1.D_OUT, 8'h88);
        set(1'b0, 1'b0, 8'h00);
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset("arst");
        #3;
        RST_N = 1'b1;
        step();
        chk("post_rst_count", i1.COUNT, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sized_fifo.md
# sized_fifo

Parametrised synchronous FIFO generalising the two-entry pipeline buffer to any depth ≥ 2. It adds occupancy count, programmable almost-full/almost-empty flags and optional sticky overflow/underflow error capture. It is the standard inter-stage buffer for the core's decoupled pipeline and bus-bridge queues wherever two entries are insufficient.

## Interface
- `width`, 1: data width in bits.
- `depth`, 4: number of entries; any integer ≥ 2, not restricted to powers of two.
- `guarded`, 1'b1: when 1, ENQ on a full FIFO is accepted if DEQ is asserted in the same cycle.
- `af_level`, depth-1: ALMOST_FULL asserts when count ≥ af_level; legal range 1..depth.
- `ae_level`, 1: ALMOST_EMPTY asserts when count ≤ ae_level; legal range 0..depth-1.
- Derived: `cw` = $clog2(depth+1), the count width.

Ports:
- `CLK` in 1: clock; all state changes on its rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CLR` in 1: synchronous clear.
- `D_IN` in width: enqueue data.
- `ENQ` in 1: enqueue request.
- `FULL_N` out 1: high when count < depth.
- `D_OUT` out width: head entry, i.e. mem[rptr].
- `DEQ` in 1: dequeue request.
- `EMPTY_N` out 1: high when count > 0.
- `COUNT` out cw: current occupancy, 0..depth.
- `ALMOST_FULL` out 1: count ≥ af_level.
- `ALMOST_EMPTY` out 1: count ≤ ae_level.
- `OVF` out 1: sticky overflow flag; only when the error macro is compiled in.
- `UDF` out 1: sticky underflow flag; only when the error macro is compiled in.

## Operation
- State: storage mem[0..depth-1], rptr and wptr in 0..depth-1, and count in 0..depth.
- Pointer increment wraps from depth-1 to 0. No reliance on binary overflow.
- write_en = ENQ & (FULL_N | (guarded & DEQ)).
- read_en = DEQ & EMPTY_N.
- Actions per {write_en, read_en}:
  - 10: mem[wptr] ← D_IN, wptr+1, count+1.
  - 01: rptr+1, count−1.
  - 11: write and read pointers both advance; count unchanged.
  - 00: hold.
- Empty with ENQ&DEQ: the read is blocked, so this is an enqueue only (count 0→1). No bypass from D_IN to D_OUT.
- Full with ENQ&DEQ:
  - guarded=1: simultaneous case, count stays at depth, and the write lands in the slot being freed.
  - guarded=0: the write is dropped, the read proceeds, count becomes depth-1.
- CLR has priority over ENQ/DEQ. It resets rptr, wptr and count to 0 and clears OVF/UDF. Storage contents are retained.
- Reset (RST_N low):
  - Immediately forces rptr, wptr, count and all storage to 0, and OVF/UDF to 0.
  - Outputs: FULL_N=1, EMPTY_N=0, COUNT=0, D_OUT=0, ALMOST_EMPTY=1 (ae_level ≥ 0), ALMOST_FULL=0.
- Reset asserted mid-operation discards all contents regardless of ENQ/DEQ.
- All status outputs are decoded combinationally from registered count. They carry no combinational path from ENQ/DEQ/D_IN.

## Timing
- Single-cycle state update. A flag or count change appears after the edge that performs the operation.
- First-word latency is 1 cycle: data enqueued at edge N is on D_OUT, with EMPTY_N=1, after edge N.
- D_OUT shows the new head after the dequeue edge. It is stable between edges while DEQ is not taken.
- Sustained throughput is one enqueue and one dequeue per cycle.
- ENQ while FULL_N=0 (and not guarded&DEQ), or DEQ while EMPTY_N=0, is a no-op on data state.
- RST_N assertion is asynchronous. Deassertion must be synchronised externally to CLK.

## Configuration
- `SIZED_FIFO_ERR_EN` defined:
  - OVF sets on any edge where ENQ & !write_en.
  - UDF sets on any edge where DEQ & !EMPTY_N.
  - Both are sticky until RST_N or CLR. An error edge coinciding with CLR leaves the flag 0.
- `SIZED_FIFO_ERR_EN` undefined: OVF and UDF are driven constant 0 and no error registers are built. All other behaviour is identical.

## Test plan
All cases use width=8, depth=5 (non-power-of-two), af_level=4, ae_level=1, guarded=1, unless stated otherwise.
1. Reset, then 5 ENQs of 0x11..0x55.
   - COUNT steps 1..5, ALMOST_FULL rises at COUNT=4, FULL_N=0 at 5, D_OUT=0x11 throughout.
2. From full, 5 DEQs.
   - D_OUT sequence is 0x22, 0x33, 0x44, 0x55; then EMPTY_N=0 and ALMOST_EMPTY=1 once COUNT ≤ 1.
3. Wrap-around:
   - Stimulus: 3 ENQ, 3 DEQ, then 7 cycles of simultaneous ENQ/DEQ with D_IN=0xA0+i.
   - Required: FIFO order is preserved across the pointer wrap 4→0, and COUNT is stable.
4. Full boundary:
   - Full plus ENQ&DEQ with guarded=1: COUNT stays 5 and the new word is read out last.
   - Same stimulus with guarded=0: COUNT becomes 4, the word is dropped, and OVF=1 (macro on).
5. Empty boundary:
   - DEQ on empty: state is unchanged and UDF=1 (macro on) or 0 (macro off).
   - ENQ&DEQ on empty: COUNT becomes 1 and D_OUT=D_IN on the next cycle.
6. With COUNT=3:
   - Assert CLR together with ENQ: COUNT=0, EMPTY_N=0, OVF/UDF cleared.
   - Then drop RST_N asynchronously mid-cycle: all outputs take their reset values before the next CLK edge.
